// File: rtl/downsizing_n.sv
// AXI-Stream width downconverter: N*W-bit beats in, W-bit words out, MSB word first.
// Empty keep words are skipped and the final kept word of a tlast beat carries tlast.
module downsizing_n #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_tdata,
  input  logic [N-1:0]     in_tkeep,
  input  logic             in_tlast,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [W-1:0]     out_tdata,
  output logic             out_tlast,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             err_empty_last
);

  logic [N*W-1:0] data_buf;
  logic [N-1:0]   pend;
  logic [N-1:0]   keep_w;
  logic [N-1:0]   sel_mask;
  logic           last_r;
  logic           one_left;
  logic           in_hs;
  logic           out_hs;

  // keep bit N-1 qualifies word 0, so flip the mask into word order
  always_comb begin
    keep_w = '0;
    for (int i = 0; i < N; i++) begin
      keep_w[i] = in_tkeep[N-1-i];
    end
  end

  // Lowest-index pending word wins; scanning downward leaves it as the final assignment
  always_comb begin
    sel_mask  = '0;
    out_tdata = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
        out_tdata   = data_buf[(N-1-i)*W +: W];
      end
    end
  end

  assign one_left   = (pend != '0) && ((pend & (pend - N'(1))) == '0);
  assign out_tvalid = (pend != '0);
  assign out_tlast  = last_r & one_left;
  assign in_tready  = (pend == '0) | (out_tready & one_left);
  assign in_hs      = in_tvalid & in_tready;
  assign out_hs     = out_tvalid & out_tready;

  // A new beat may only arrive as the last word leaves, so the load overrides the clear
  always_ff @(posedge aclk) begin
    if (rst) begin
      pend           <= '0;
      last_r         <= 1'b0;
      err_empty_last <= 1'b0;
    end else begin
      err_empty_last <= in_hs & in_tlast & (in_tkeep == '0);
      if (in_hs) begin
        pend   <= keep_w;
        last_r <= in_tlast;
      end else if (out_hs) begin
        pend <= pend & ~sel_mask;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (in_hs) begin
      data_buf <= in_tdata;
    end
  end

endmodule

// File: tb/tb_downsizing_n.sv
// Bench for downsizing_n: word-queue reference model checked every cycle,
// directed packets with literal expectations, then randomized backpressure.
module tb_downsizing_n;
  localparam int W = 32;
  localparam int N = 4;

  logic           aclk;
  logic           rst;
  logic [N*W-1:0] in_tdata;
  logic [N-1:0]   in_tkeep;
  logic           in_tlast;
  logic           in_tvalid;
  logic           in_tready;
  logic [W-1:0]   out_tdata;
  logic           out_tlast;
  logic           out_tvalid;
  logic           out_tready;
  logic           err_empty_last;

  downsizing_n #(.W(W), .N(N)) dut (
    .aclk(aclk), .rst(rst),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .err_empty_last(err_empty_last)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = 0;
  int err_pulses = 0;
  logic [W:0] q[$];
  logic [W:0] got[$];
  int got_c[$];
  bit armed = 0;
  bit prev_stall = 0;
  bit err_exp = 0;
  logic [W-1:0] prev_data;

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc++;

  // out_tready pattern generator
  always @(posedge aclk) begin
    #2;
    case (mode)
      0: out_tready = 1'b1;
      1: out_tready = ~out_tready;
      2: out_tready = 1'($urandom_range(0, 1));
      default: out_tready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of owed words {last, data}; compared every cycle
  always @(negedge aclk) begin
    bit in_hs;
    bit out_hs;
    int added;
    if (rst) begin
      q.delete();
      err_exp = 0;
      prev_stall = 0;
      armed = 1;
    end else if (armed) begin
      chk("valid", out_tvalid, q.size() != 0);
      chk("in_tready", in_tready, (q.size() == 0) || (out_tready && q.size() == 1));
      chk("err_empty_last", err_empty_last, err_exp);
      if (out_tvalid && q.size() != 0) begin
        chk("data", out_tdata, q[0][W-1:0]);
        chk("last", out_tlast, q[0][W]);
      end
      if (prev_stall) chk("hold", out_tdata, prev_data);
      if (err_empty_last === 1'b1) err_pulses++;
      in_hs = in_tvalid & in_tready;
      out_hs = out_tvalid & out_tready;
      prev_stall = out_tvalid & ~out_tready;
      prev_data = out_tdata;
      err_exp = in_hs & in_tlast & (in_tkeep == '0);
      if (out_hs) begin
        got.push_back({out_tlast, out_tdata});
        got_c.push_back(cyc);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_hs) begin
        added = 0;
        for (int i = 0; i < N; i++) begin
          if (in_tkeep[N-1-i]) begin
            q.push_back({1'b0, in_tdata[(N-1-i)*W +: W]});
            added++;
          end
        end
        if (in_tlast && added > 0) q[q.size()-1][W] = 1'b1;
      end
    end
  end

  // Called and returns at posedge+1 phase
  task automatic send(input logic [N*W-1:0] d, input logic [N-1:0] k, input logic l);
    int n = 0;
    bit hs = 0;
    in_tdata = d;
    in_tkeep = k;
    in_tlast = l;
    in_tvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge aclk);
      hs = in_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL send_timeout: actual=no handshake required=handshake within 200 cycles");
    end
    in_tvalid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((q.size() != 0 || out_tvalid) && n < lim) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: actual=%0d words pending required=0", q.size());
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [N*W-1:0] b1;
    logic [N*W-1:0] b2;
    logic [N*W-1:0] b3;
    int e0;
    int n;
    b1 = "ABCDEFGHIJKLMNOP";
    b2 = "QRSTUVWXYZ012345";
    b3 = "abcdefghijklmnop";
    in_tvalid = 0;
    in_tdata = '0;
    in_tkeep = '0;
    in_tlast = 0;
    out_tready = 1;
    rst = 1;
    repeat (3) @(posedge aclk);
    #1 rst = 0;
    @(negedge aclk);
    chk("rst_valid", out_tvalid, 0);
    chk("rst_in_tready", in_tready, 1);
    chk("rst_err", err_empty_last, 0);
    @(posedge aclk);
    #1;

    // back-to-back full beats, no backpressure
    got.delete(); got_c.delete();
    send(b1, 4'hF, 1'b0);
    send(b2, 4'hF, 1'b0);
    drain(100);
    chk("t1_count", got.size(), 8);
    if (got.size() == 8) begin
      chk("t1_w0", got[0], {1'b0, 32'h41424344});
      chk("t1_w3", got[3], {1'b0, 32'h4D4E4F50});
      chk("t1_w4", got[4], {1'b0, 32'h51525354});
      chk("t1_span", got_c[7] - got_c[0], 7);
    end

    // toggling out_tready, tlast on final word only
    got.delete(); got_c.delete();
    out_tready = 0;
    mode = 1;
    send(b1, 4'hF, 1'b1);
    drain(100);
    mode = 0;
    chk("t2_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t2_w2", got[2], {1'b0, 32'h494A4B4C});
      chk("t2_w3", got[3], {1'b1, 32'h4D4E4F50});
    end

    // sparse keep: words 0 and 2
    got.delete(); got_c.delete();
    send(b1, 4'b1010, 1'b1);
    drain(100);
    chk("t3_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t3_w0", got[0], {1'b0, 32'h41424344});
      chk("t3_w1", got[1], {1'b1, 32'h494A4B4C});
      chk("t3_gap", got_c[1] - got_c[0], 1);
    end

    // empty tlast beat then single-word beat
    got.delete(); got_c.delete();
    e0 = err_pulses;
    send(b2, 4'b0000, 1'b1);
    send(b1, 4'b0001, 1'b1);
    drain(100);
    repeat (2) @(posedge aclk);
    #1;
    chk("t4_err_pulses", err_pulses - e0, 1);
    chk("t4_count", got.size(), 1);
    if (got.size() == 1) chk("t4_w", got[0], {1'b1, 32'h4D4E4F50});

    // reset after two of four words
    got.delete(); got_c.delete();
    send(b1, 4'hF, 1'b1);
    n = 0;
    while (got.size() < 2 && n < 50) begin
      @(posedge aclk);
      #1;
      n++;
    end
    rst = 1;
    @(posedge aclk);
    #1 rst = 0;
    @(negedge aclk);
    chk("t5_valid", out_tvalid, 0);
    chk("t5_in_tready", in_tready, 1);
    chk("t5_before", got.size(), 2);
    @(posedge aclk);
    #1;
    got.delete(); got_c.delete();
    send(b3, 4'hF, 1'b1);
    drain(100);
    chk("t5_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t5_w0", got[0], {1'b0, 32'h61626364});
      chk("t5_w3", got[3], {1'b1, 32'h6D6E6F70});
    end

    // random backpressure, full then random keep
    got.delete(); got_c.delete();
    mode = 2;
    repeat (18) send({$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'($urandom_range(0, 1)));
    drain(1000);
    chk("t6_count", got.size(), 72);
    chk("t6_q_empty", q.size(), 0);
    repeat (12) send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    drain(1000);
    chk("t6_q_empty2", q.size(), 0);
    mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
